// File: rtl/z80_bus_responder_if.sv
// CPU-side bus of the z80_bus_responder: address, write data, strobes, read data and wait.
// The CPU (or a bench acting as one) uses the master modport and the responder uses the slave modport.
interface z80_bus_responder_if;
    logic [15:0] A;
    logic [7:0]  cpu_do;
    logic        mreq_n;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic        m1_n;
    logic        rfsh_n;
    logic [7:0]  di;
    logic        wait_n;

    modport master (
        output A, cpu_do, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n,
        input  di, wait_n
    );

    modport slave (
        input  A, cpu_do, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n,
        output di, wait_n
    );
endinterface

// File: rtl/z80_bus_responder.sv
// Memory/IO slave for a tv80s-style bus with wait-state insertion and interrupt-acknowledge vector.
// Define Z80_RESP_IO_EN to map IO cycles onto the {IO_BASE[15:8], A[7:0]} window of the array.
module z80_bus_responder #(
    parameter int          ADDR_W      = 16,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [15:0] IO_BASE     = 16'h1000,
    parameter logic [7:0]  INT_VECTOR  = 8'hFF
) (
    input  logic                  clk,
    input  logic                  reset,
    z80_bus_responder_if.slave    bus,
    input  logic                  ld_en,
    input  logic [15:0]           ld_addr,
    input  logic [7:0]            ld_data,
    output logic                  busy,
    output logic [15:0]           wr_count
);
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_HOLD} state_t;
    typedef enum logic [1:0] {CL_MEM, CL_IO, CL_INTA} cls_t;

    localparam int         MEM_DEPTH = 1 << ADDR_W;
    localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);
    localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;
`ifdef Z80_RESP_IO_EN
    localparam bit         IO_EN     = 1'b1;
`else
    localparam bit         IO_EN     = 1'b0;
`endif

    logic [7:0]        mem_q [MEM_DEPTH];
    state_t            state_q;
    cls_t              cls_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        wcnt_q;
    logic [7:0]        di_q;
    logic              wait_n_q;
    logic              busy_q;
    logic [15:0]       wr_count_q;

    logic              mem_cyc_s;
    logic              io_cyc_s;
    logic              inta_cyc_s;
    logic              strobe_off_s;
    logic [15:0]       io_full_s;
    logic              req_hit_s;
    cls_t              req_cls_d;
    logic [ADDR_W-1:0] req_addr_d;
    logic              req_wait_d;
    logic [7:0]        rd_data_s;
    logic              wr_ok_s;
    logic              wr_commit_s;

    // Refresh shares mreq_n with memory cycles, so rfsh_n must be high for a real access.
    assign mem_cyc_s    = !bus.mreq_n && bus.rfsh_n;
    assign io_cyc_s     = !bus.iorq_n && bus.m1_n;
    assign inta_cyc_s   = !bus.iorq_n && !bus.m1_n;
    assign strobe_off_s = bus.mreq_n && bus.iorq_n;
    assign io_full_s    = {IO_BASE[15:8], bus.A[7:0]};

    // Classify a new bus cycle and pick its array address and wait policy.
    always_comb begin
        req_hit_s  = 1'b0;
        req_cls_d  = CL_MEM;
        req_addr_d = bus.A[ADDR_W-1:0];
        req_wait_d = HAS_WAIT;
        if (mem_cyc_s) begin
            req_hit_s = 1'b1;
        end else if (inta_cyc_s) begin
            req_hit_s = 1'b1;
            req_cls_d = CL_INTA;
        end else if (io_cyc_s) begin
            req_hit_s  = 1'b1;
            req_cls_d  = CL_IO;
            req_addr_d = io_full_s[ADDR_W-1:0];
            req_wait_d = HAS_WAIT && IO_EN;
        end else begin
            req_hit_s = 1'b0;
        end
    end

    // Byte presented on di for the latched cycle.
    always_comb begin
        if (cls_q == CL_INTA) begin
            rd_data_s = INT_VECTOR;
        end else if ((cls_q == CL_IO) && !IO_EN) begin
            rd_data_s = 8'hFF;
        end else begin
            rd_data_s = mem_q[addr_q];
        end
    end

    assign wr_ok_s     = (cls_q == CL_MEM) || ((cls_q == CL_IO) && IO_EN);
    assign wr_commit_s = (state_q == ST_ACCESS) && (cls_q != CL_INTA) && bus.rd_n && !bus.wr_n && wr_ok_s;

    // Array write port; the backdoor load is applied last so it wins a same-address collision.
    always_ff @(negedge clk) begin
        if (wr_commit_s) begin
            mem_q[addr_q] <= bus.cpu_do;
        end
        if (ld_en) begin
            mem_q[ld_addr[ADDR_W-1:0]] <= ld_data;
        end
    end

    // Bus-cycle FSM with registered di, wait_n, busy and write counter.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cls_q      <= CL_MEM;
            addr_q     <= '0;
            wcnt_q     <= 4'd0;
            di_q       <= 8'hFF;
            wait_n_q   <= 1'b1;
            busy_q     <= 1'b0;
            wr_count_q <= 16'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    di_q <= 8'hFF;
                    if (req_hit_s) begin
                        cls_q  <= req_cls_d;
                        addr_q <= req_addr_d;
                        busy_q <= 1'b1;
                        if (req_wait_d) begin
                            state_q  <= ST_WAIT;
                            wait_n_q <= 1'b0;
                            wcnt_q   <= WAIT_LOAD;
                        end else begin
                            state_q <= ST_ACCESS;
                        end
                    end
                end
                ST_WAIT: begin
                    if (strobe_off_s) begin
                        state_q  <= ST_IDLE;
                        wait_n_q <= 1'b1;
                        busy_q   <= 1'b0;
                    end else if (wcnt_q == 4'd0) begin
                        state_q  <= ST_ACCESS;
                        wait_n_q <= 1'b1;
                    end else begin
                        wcnt_q <= wcnt_q - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    // tv80 drops wr_n one T-state late, so ACCESS may idle here before the write lands.
                    if ((cls_q == CL_INTA) || !bus.rd_n) begin
                        di_q    <= rd_data_s;
                        state_q <= ST_HOLD;
                    end else if (!bus.wr_n) begin
                        if (wr_ok_s) begin
                            wr_count_q <= wr_count_q + 16'd1;
                        end
                        state_q <= ST_HOLD;
                    end else if (strobe_off_s) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        di_q    <= 8'hFF;
                    end
                end
                ST_HOLD: begin
                    if (strobe_off_s) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        di_q    <= 8'hFF;
                    end else if (!bus.rd_n) begin
                        di_q <= rd_data_s;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    wait_n_q <= 1'b1;
                    busy_q   <= 1'b0;
                    di_q     <= 8'hFF;
                end
            endcase
        end
    end

    assign bus.di     = di_q;
    assign bus.wait_n = wait_n_q;
    assign busy       = busy_q;
    assign wr_count   = wr_count_q;
endmodule
